// File: rtl/om_port_sched.sv
// om_port_sched: owner of the single-port output memory (OM).
// Each cycle it chooses the source driving the OM pins: the OutputStage,
// the WBuffer (clear and store bursts) or the host readback port. It also
// generates back-pressure (STALL_om) and the mux select (OMSRC).
// Optional build macro: OM_COLLISION_CHK_EN adds a sticky COLLISION_ERR output.
module om_port_sched #(
  parameter int AW         = 4,
  parameter int DW         = 64,
  parameter int STARVE_MAX = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          INIT_DONE,
  input  logic          LOAD_DONE,
  input  logic          STORE_DONE,
  input  logic [AW-1:0] ODST_wb,
  input  logic          EN_wb,
  input  logic [DW-1:0] WData_wb,
  input  logic [AW-1:0] ODST_om,
  input  logic          OMWrite_om,
  input  logic [DW-1:0] OData_om,
  output logic          STALL_om,
  output logic          OMSRC,
  input  logic          HRD_REQ,
  input  logic [AW-1:0] HRD_ADDR,
  output logic          HRD_ACK,
  output logic          HRD_VALID,
  output logic [DW-1:0] HRD_DATA,
  output logic [AW-1:0] OM_ADDR,
  output logic          OM_WE,
  output logic [DW-1:0] OM_WDATA,
  output logic          OM_RE,
  input  logic [DW-1:0] OM_RDATA
`ifdef OM_COLLISION_CHK_EN
  ,
  output logic          COLLISION_ERR
`endif
);

  localparam int CW = (STARVE_MAX > 2) ? $clog2(STARVE_MAX) : 1;
  localparam logic [CW-1:0] C_SAT = CW'(STARVE_MAX - 1);

  typedef enum logic [1:0] {S_INIT, S_NORM, S_SWITCH, S_WB} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_starve;
  logic          r_hrd_vld_p1;
  logic          w_forced;

  // A waiting host read has reached its patience limit and takes the slot.
  assign w_forced = (r_starve == C_SAT) && HRD_REQ;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_INIT;
    else     r_state <= w_state_nxt;
  end

  // Next state and per-cycle OM pin arbitration.
  always_comb begin
    w_state_nxt = r_state;
    OMSRC       = 1'b0;
    STALL_om    = 1'b0;
    HRD_ACK     = 1'b0;
    OM_ADDR     = '0;
    OM_WE       = 1'b0;
    OM_WDATA    = '0;
    OM_RE       = 1'b0;
    case (r_state)
      S_INIT: begin
        OMSRC    = 1'b1;
        STALL_om = 1'b1;
        OM_ADDR  = ODST_wb;
        OM_WE    = EN_wb;
        OM_WDATA = WData_wb;
        if (INIT_DONE) w_state_nxt = S_NORM;
      end
      S_NORM: begin
        if (LOAD_DONE) begin
          // Hand-over cycle: OM stays idle, OutputStage is held off.
          STALL_om    = 1'b1;
          w_state_nxt = S_SWITCH;
        end else if (w_forced) begin
          STALL_om = 1'b1;
          OM_RE    = 1'b1;
          HRD_ACK  = 1'b1;
          OM_ADDR  = HRD_ADDR;
        end else if (OMWrite_om) begin
          OM_WE    = 1'b1;
          OM_ADDR  = ODST_om;
          OM_WDATA = OData_om;
        end else if (HRD_REQ) begin
          OM_RE    = 1'b1;
          HRD_ACK  = 1'b1;
          OM_ADDR  = HRD_ADDR;
        end
      end
      S_SWITCH: begin
        OMSRC       = 1'b1;
        STALL_om    = 1'b1;
        w_state_nxt = S_WB;
      end
      S_WB: begin
        OMSRC    = 1'b1;
        STALL_om = 1'b1;
        OM_ADDR  = ODST_wb;
        OM_WE    = EN_wb;
        OM_WDATA = WData_wb;
        // The STORE_DONE write itself still lands this cycle.
        if (STORE_DONE) w_state_nxt = S_NORM;
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  // Host starvation counter: counts refused request cycles, saturating.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_starve <= '0;
    end else if (!HRD_REQ || HRD_ACK) begin
      r_starve <= '0;
    end else if ((r_state != S_INIT) && (r_starve != C_SAT)) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  // Read return: valid one cycle after the grant, aligned with OM_RDATA.
  always_ff @(posedge CLK) begin
    if (RST) r_hrd_vld_p1 <= 1'b0;
    else     r_hrd_vld_p1 <= HRD_ACK;
  end

  assign HRD_VALID = r_hrd_vld_p1;
  assign HRD_DATA  = r_hrd_vld_p1 ? OM_RDATA : '0;

`ifdef OM_COLLISION_CHK_EN
  logic r_coll;

  // Sticky flag for WBuffer activity arriving while the OM is not handed to it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_coll <= 1'b0;
    end else if ((EN_wb && !OMSRC) || (STORE_DONE && (r_state != S_WB))) begin
      r_coll <= 1'b1;
    end
  end

  assign COLLISION_ERR = r_coll;
`endif

endmodule

// File: tb/tb_om_port_sched.sv
// Bench for om_port_sched: directed vector table, randomized traffic checked
// against a rule-level reference model, and hand-written corner sequences.
module tb_om_port_sched;

  localparam int AW = 4;
  localparam int DW = 64;
  localparam int SMAX = 8;

  logic          CLK, RST, INIT_DONE, LOAD_DONE, STORE_DONE;
  logic [AW-1:0] ODST_wb, ODST_om, HRD_ADDR, OM_ADDR;
  logic          EN_wb, OMWrite_om, HRD_REQ;
  logic [DW-1:0] WData_wb, OData_om, HRD_DATA, OM_WDATA, OM_RDATA;
  logic          STALL_om, OMSRC, HRD_ACK, HRD_VALID, OM_WE, OM_RE;
`ifdef OM_COLLISION_CHK_EN
  logic          COLLISION_ERR;
`endif

  om_port_sched #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .RST(RST), .INIT_DONE(INIT_DONE), .LOAD_DONE(LOAD_DONE),
    .STORE_DONE(STORE_DONE), .ODST_wb(ODST_wb), .EN_wb(EN_wb), .WData_wb(WData_wb),
    .ODST_om(ODST_om), .OMWrite_om(OMWrite_om), .OData_om(OData_om),
    .STALL_om(STALL_om), .OMSRC(OMSRC), .HRD_REQ(HRD_REQ), .HRD_ADDR(HRD_ADDR),
    .HRD_ACK(HRD_ACK), .HRD_VALID(HRD_VALID), .HRD_DATA(HRD_DATA),
    .OM_ADDR(OM_ADDR), .OM_WE(OM_WE), .OM_WDATA(OM_WDATA), .OM_RE(OM_RE),
`ifdef OM_COLLISION_CHK_EN
    .COLLISION_ERR(COLLISION_ERR),
`endif
    .OM_RDATA(OM_RDATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Physical single-port memory with registered read data.
  logic [DW-1:0] mem [16];
  always @(posedge CLK) begin
    if (OM_WE) mem[OM_ADDR] <= OM_WDATA;
    if (OM_RE) OM_RDATA <= mem[OM_ADDR];
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic chk1(input string nm, input logic a, input logic e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b", nm, a, e);
    end
  endtask

  // Reference model: mode 0=init 1=normal 2=switch 3=wbuffer window.
  int            m_st;
  int            m_cnt;
  logic          m_vld;
  logic [DW-1:0] m_data;
  logic [DW-1:0] exp_mem [16];
  logic          e_stall, e_src, e_ack, e_we, e_re;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;

  task automatic model_eval();
    e_stall = 1'b0; e_src = 1'b0; e_ack = 1'b0; e_we = 1'b0; e_re = 1'b0;
    e_addr = '0; e_wdata = '0;
    if (m_st == 0 || m_st == 3) begin
      e_src = 1'b1; e_stall = 1'b1;
      e_we = EN_wb; e_addr = ODST_wb; e_wdata = WData_wb;
    end else if (m_st == 2) begin
      e_src = 1'b1; e_stall = 1'b1;
    end else begin
      if (LOAD_DONE) e_stall = 1'b1;
      else if (m_cnt == SMAX - 1 && HRD_REQ) begin
        e_stall = 1'b1; e_re = 1'b1; e_ack = 1'b1; e_addr = HRD_ADDR;
      end else if (OMWrite_om) begin
        e_we = 1'b1; e_addr = ODST_om; e_wdata = OData_om;
      end else if (HRD_REQ) begin
        e_re = 1'b1; e_ack = 1'b1; e_addr = HRD_ADDR;
      end
    end
  endtask

  task automatic model_update();
    m_vld  = e_ack;
    m_data = exp_mem[e_addr];
    if (e_we) exp_mem[e_addr] = e_wdata;
    if (!HRD_REQ || e_ack) m_cnt = 0;
    else if (m_st != 0 && m_cnt < SMAX - 1) m_cnt = m_cnt + 1;
    case (m_st)
      0: if (INIT_DONE) m_st = 1;
      1: if (LOAD_DONE) m_st = 2;
      2: m_st = 3;
      default: if (STORE_DONE) m_st = 1;
    endcase
    if (RST) begin
      m_st = 0; m_cnt = 0; m_vld = 1'b0; m_data = '0;
    end
  endtask

  task automatic compare_model();
    chk1("stall", STALL_om, e_stall);
    chk1("omsrc", OMSRC, e_src);
    chk1("ack", HRD_ACK, e_ack);
    chk1("we", OM_WE, e_we);
    chk1("re", OM_RE, e_re);
    if (e_we || e_re) chk("addr", 64'(OM_ADDR), 64'(e_addr));
    if (e_we) chk("wdata", OM_WDATA, e_wdata);
    chk1("hrd_valid", HRD_VALID, m_vld);
    if (m_vld) chk("hrd_data", HRD_DATA, m_data);
    chk1("we_re_excl", OM_WE && OM_RE, 1'b0);
  endtask

  task automatic tick_a();
    @(negedge CLK);
    model_eval();
  endtask

  task automatic tick_b();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  typedef struct {
    logic wr; logic [3:0] wa; logic [63:0] wd;
    logic rq; logic [3:0] ra;
    logic ld, sd, en; logic [3:0] ea;
    logic xs, xc, xk, xw, xr; logic [3:0] xa;
    logic xv; logic [63:0] xd;
  } vec_t;

  function automatic vec_t V(int wr, int wa, int wd, int rq, int ra, int ld, int sd,
                             int en, int ea, int xs, int xc, int xk, int xw, int xr,
                             int xa, int xv, int xd);
    vec_t r;
    r.wr = (wr != 0); r.wa = 4'(wa); r.wd = 64'(wd);
    r.rq = (rq != 0); r.ra = 4'(ra);
    r.ld = (ld != 0); r.sd = (sd != 0); r.en = (en != 0); r.ea = 4'(ea);
    r.xs = (xs != 0); r.xc = (xc != 0); r.xk = (xk != 0);
    r.xw = (xw != 0); r.xr = (xr != 0); r.xa = 4'(xa);
    r.xv = (xv != 0); r.xd = 64'(xd);
    return r;
  endfunction

  vec_t tbl [16];

  initial begin
    int we_cnt;
    int ack_at;

    //  wr wa wd      rq ra ld sd en ea  stl src ack we re addr vld data
    tbl[0]  = V(1, 7, 'h77, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 7,  0, 0);
    tbl[1]  = V(1, 3, 'hA5, 1, 7, 0, 0, 0, 0,  0, 0, 0, 1, 0, 3,  0, 0);
    tbl[2]  = V(0, 0, 0,    1, 7, 0, 0, 0, 0,  0, 0, 1, 0, 1, 7,  0, 0);
    tbl[3]  = V(0, 0, 0,    0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  1, 'h77);
    tbl[4]  = V(1, 4, 'h44, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0,  0, 0);
    tbl[5]  = V(1, 4, 'h44, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0,  0, 0);
    tbl[6]  = V(1, 4, 'h44, 0, 0, 0, 0, 1, 2,  1, 1, 0, 1, 0, 2,  0, 0);
    tbl[7]  = V(1, 4, 'h44, 0, 0, 0, 0, 1, 5,  1, 1, 0, 1, 0, 5,  0, 0);
    tbl[8]  = V(1, 4, 'h44, 0, 0, 0, 0, 1, 9,  1, 1, 0, 1, 0, 9,  0, 0);
    tbl[9]  = V(1, 4, 'h44, 0, 0, 0, 1, 1, 12, 1, 1, 0, 1, 0, 12, 0, 0);
    tbl[10] = V(1, 4, 'h44, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 4,  0, 0);
    tbl[11] = V(0, 0, 0,    1, 9, 0, 0, 0, 0,  0, 0, 1, 0, 1, 9,  0, 0);
    tbl[12] = V(0, 0, 0,    0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  1, 'h1009);
    tbl[13] = V(0, 0, 0,    0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0,  0, 0);
    tbl[14] = V(0, 0, 0,    0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0);
    tbl[15] = V(0, 0, 0,    0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0);

    RST = 1'b1; INIT_DONE = 1'b0; LOAD_DONE = 1'b0; STORE_DONE = 1'b0;
    ODST_wb = '0; EN_wb = 1'b0; WData_wb = '0; ODST_om = '0; OMWrite_om = 1'b0;
    OData_om = '0; HRD_REQ = 1'b0; HRD_ADDR = '0;
    m_st = 0; m_cnt = 0; m_vld = 1'b0; m_data = '0;
    for (int i = 0; i < 16; i++) exp_mem[i] = '0;

    tick_a(); tick_b();
    RST = 1'b0;
    chk1("rst_hrd_valid", HRD_VALID, 1'b0);
    chk("rst_hrd_data", HRD_DATA, 64'h0);
    chk1("rst_omsrc", OMSRC, 1'b1);
    chk1("rst_stall", STALL_om, 1'b1);

    // OM clear burst while INIT_DONE is low.
    we_cnt = 0;
    for (int a = 0; a < 16; a++) begin
      EN_wb = 1'b1; ODST_wb = 4'(a); WData_wb = '0;
      tick_a();
      compare_model();
      if (OM_WE) we_cnt++;
      tick_b();
    end
    chk("init_we_pulses", 64'(we_cnt), 64'd16);
    EN_wb = 1'b0; INIT_DONE = 1'b1;
    tick_a(); compare_model(); tick_b();
    chk1("init_done_omsrc", OMSRC, 1'b0);
`ifdef OM_COLLISION_CHK_EN
    chk1("coll_clear", COLLISION_ERR, 1'b0);
`endif

    // Directed vector table.
    for (int i = 0; i < 16; i++) begin
      OMWrite_om = tbl[i].wr; ODST_om = tbl[i].wa; OData_om = tbl[i].wd;
      HRD_REQ = tbl[i].rq; HRD_ADDR = tbl[i].ra;
      LOAD_DONE = tbl[i].ld; STORE_DONE = tbl[i].sd;
      EN_wb = tbl[i].en; ODST_wb = tbl[i].ea; WData_wb = 64'h1000 + 64'(tbl[i].ea);
      tick_a();
      chk1($sformatf("t%0d_stall", i), STALL_om, tbl[i].xs);
      chk1($sformatf("t%0d_omsrc", i), OMSRC, tbl[i].xc);
      chk1($sformatf("t%0d_ack", i), HRD_ACK, tbl[i].xk);
      chk1($sformatf("t%0d_we", i), OM_WE, tbl[i].xw);
      chk1($sformatf("t%0d_re", i), OM_RE, tbl[i].xr);
      if (tbl[i].xw || tbl[i].xr) chk($sformatf("t%0d_addr", i), 64'(OM_ADDR), 64'(tbl[i].xa));
      chk1($sformatf("t%0d_hvalid", i), HRD_VALID, tbl[i].xv);
      if (tbl[i].xv) chk($sformatf("t%0d_hdata", i), HRD_DATA, tbl[i].xd);
      tick_b();
    end
`ifdef OM_COLLISION_CHK_EN
    chk1("coll_set", COLLISION_ERR, 1'b1);
`endif

    // Randomized traffic against the reference model, honouring hold rules.
    for (int n = 0; n < 400; n++) begin
      if (!(HRD_REQ && !e_ack)) begin
        HRD_REQ = ($urandom % 3) == 0; HRD_ADDR = 4'($urandom);
      end
      if (!(OMWrite_om && e_stall)) begin
        OMWrite_om = ($urandom % 2) == 1; ODST_om = 4'($urandom);
        OData_om = {$urandom, $urandom};
      end
      LOAD_DONE = ($urandom % 16) == 0;
      STORE_DONE = (m_st == 3) ? (($urandom % 4) == 0) : (($urandom % 50) == 0);
      EN_wb = ($urandom % 2) == 1; ODST_wb = 4'($urandom); WData_wb = {$urandom, $urandom};
      tick_a(); compare_model(); tick_b();
    end

    // Return to normal operation with no pending traffic.
    HRD_REQ = 1'b0; OMWrite_om = 1'b0; LOAD_DONE = 1'b0; EN_wb = 1'b0;
    for (int k = 0; k < 6; k++) begin
      STORE_DONE = (m_st == 3);
      tick_a(); compare_model(); tick_b();
    end
    STORE_DONE = 1'b0;
    tick_a(); compare_model();
    chk1("settle_omsrc", OMSRC, 1'b0);
    tick_b();

    // Continuous OutputStage writes starve the host until the forced slot.
    OMWrite_om = 1'b1; ODST_om = 4'd6; OData_om = 64'h66;
    HRD_REQ = 1'b1; HRD_ADDR = 4'd3;
    ack_at = -1;
    for (int k = 0; k < 20; k++) begin
      tick_a(); compare_model();
      if (HRD_ACK && ack_at < 0) begin
        ack_at = k;
        chk1("starve_stall", STALL_om, 1'b1);
        chk1("starve_no_we", OM_WE, 1'b0);
      end
      tick_b();
      if (ack_at >= 0) break;
    end
    chk("starve_ack_cycle", 64'(ack_at), 64'd7);
    HRD_REQ = 1'b0;
    tick_a(); compare_model();
    chk1("starve_hvalid", HRD_VALID, 1'b1);
    tick_b();
    OMWrite_om = 1'b0;

    // Reset in the middle of a WBuffer window.
    LOAD_DONE = 1'b1;
    tick_a(); compare_model(); tick_b();
    LOAD_DONE = 1'b0;
    tick_a(); compare_model(); tick_b();
    EN_wb = 1'b1; ODST_wb = 4'd8; WData_wb = 64'h88;
    tick_a(); compare_model(); tick_b();
    RST = 1'b1; EN_wb = 1'b0;
    tick_a(); tick_b();
    RST = 1'b0;
    chk1("rst_wb_omsrc", OMSRC, 1'b1);
    chk1("rst_wb_stall", STALL_om, 1'b1);
    chk1("rst_wb_hvalid", HRD_VALID, 1'b0);
    tick_a(); compare_model(); tick_b();

    // Reset on the cycle of a host grant: the read never returns.
    HRD_REQ = 1'b1; HRD_ADDR = 4'd7; RST = 1'b1;
    tick_a();
    chk1("rst_ack_granted", HRD_ACK, 1'b1);
    tick_b();
    RST = 1'b0; HRD_REQ = 1'b0;
    chk1("rst_ack_hvalid", HRD_VALID, 1'b0);
    chk1("rst_ack_omsrc", OMSRC, 1'b1);
`ifdef OM_COLLISION_CHK_EN
    chk1("coll_rst", COLLISION_ERR, 1'b0);
`endif
    for (int k = 0; k < 3; k++) begin
      tick_a(); compare_model(); tick_b();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/om_port_sched.md
Name: om_port_sched

Overview:
- Owns the single-port output memory (OM) and decides each cycle which source drives its address/data pins.
- Sources: OutputStage direct writes, WBuffer init/store bursts, and a host readback port.
- Generates OMSRC (mux select) and STALL_om back-pressure; sequences the WBuffer LOAD_DONE -> STORE -> STORE_DONE window.
- Host reads are guarded by an anti-starvation counter.

Parameters:
AW, 4, OM address width
DW, 64, OM data width
STARVE_MAX, 8, host-request wait cycles before a forced read slot (>=2)

Ports:
CLK  in  1  clock, single domain
RST  in  1  synchronous active-high reset
INIT_DONE  in  1  WBuffer finished OM clear (level, stays high)
LOAD_DONE  in  1  WBuffer rows collected, 1-cycle pulse
STORE_DONE  in  1  WBuffer last store write, 1-cycle pulse
ODST_wb  in  AW  WBuffer write address
EN_wb  in  1  WBuffer write enable
WData_wb  in  DW  WBuffer write data
ODST_om  in  AW  OutputStage write address
OMWrite_om  in  1  OutputStage write request; held while STALL_om=1
OData_om  in  DW  OutputStage write data
STALL_om  out  1  OutputStage must hold its request
OMSRC  out  1  0=OutputStage/host, 1=WBuffer
HRD_REQ  in  1  host read request; held until HRD_ACK
HRD_ADDR  in  AW  host read address
HRD_ACK  out  1  read issued this cycle
HRD_VALID  out  1  HRD_DATA valid, 1-cycle pulse
HRD_DATA  out  DW  read data
OM_ADDR  out  AW  memory address
OM_WE  out  1  memory write enable
OM_WDATA  out  DW  memory write data
OM_RE  out  1  memory read enable
OM_RDATA  in  DW  read data, 1-cycle latency after OM_RE

Behaviour:
- Reset clears all state on the CLK edge with RST=1. State=S_INIT; registered outputs 0: HRD_VALID, HRD_DATA, starve counter. RST mid-operation aborts any window; an in-flight read produces no HRD_VALID.
- OM_ADDR/OM_WE/OM_WDATA/OM_RE, HRD_ACK and STALL_om are combinational from state and inputs. OMSRC is decoded from state (1 in S_INIT, S_SWITCH, S_WB).
- S_INIT:
  - OMSRC=1; OM pins follow the WBuffer inputs (OM_WE=EN_wb); STALL_om=1; no host grant.
  - INIT_DONE=1 -> S_NORM.
- S_NORM, priority order:
  1. LOAD_DONE=1 -> STALL_om=1, no grant this cycle, next state S_SWITCH.
  2. Starve counter == STARVE_MAX-1 with HRD_REQ=1 -> forced host read: STALL_om=1, OM_RE=1, HRD_ACK=1.
  3. OMWrite_om=1 -> OM_WE=1, OM_ADDR=ODST_om, OM_WDATA=OData_om.
  4. HRD_REQ=1 -> OM_RE=1, OM_ADDR=HRD_ADDR, HRD_ACK=1.
- S_SWITCH: 1 cycle, OMSRC=1, STALL_om=1, OM idle -> S_WB.
- S_WB:
  - OMSRC=1, STALL_om=1, pins follow the WBuffer inputs.
  - Exit to S_NORM on the cycle after STORE_DONE=1; that STORE_DONE cycle's write still completes.
- Starve counter:
  - Increments each S_NORM/S_SWITCH/S_WB cycle with HRD_REQ=1 and no HRD_ACK; saturates at STARVE_MAX-1.
  - Clears on HRD_ACK or HRD_REQ=0.
- HRD_VALID=1 and HRD_DATA=OM_RDATA exactly 1 cycle after HRD_ACK.
- OM_WE and OM_RE are never both 1.
- EN_wb outside S_INIT/S_WB is dropped (OM_WE=0).
- OMWrite_om under STALL_om is not written; OutputStage retries.
- LOAD_DONE outside S_NORM is ignored.
- LOAD_DONE and a forced-read slot in the same cycle: LOAD_DONE wins; the counter holds its saturated value.

Optional Feature:
- Macro OM_COLLISION_CHK_EN.
- Defined: adds output COLLISION_ERR (1 bit, sticky until RST). It sets the cycle after either:
  - EN_wb=1 while OMSRC=0, or
  - STORE_DONE=1 outside S_WB.
- Undefined: port absent; such events are silently dropped as above.

Test Plan:
- RST 1 cycle, INIT_DONE low 16 cycles with EN_wb addr 0..15, data 0 -> 16 OM_WE pulses, OMSRC=1, STALL_om=1; INIT_DONE=1 -> OMSRC=0 next cycle.
- S_NORM: OMWrite_om addr 3 data 0xA5 together with HRD_REQ addr 7 -> write to 3 that cycle; read of 7 next cycle (HRD_ACK); HRD_VALID one cycle later carrying OM[7].
- LOAD_DONE at t, EN_wb addr 2,5,9,12 from t+2 to t+5, STORE_DONE at t+5 -> OMSRC=1 over t+1..t+5; STALL_om=1 over t..t+5; OutputStage write at t+3 held, written at t+6.
- OMWrite_om held every cycle with HRD_REQ=1 -> forced HRD_ACK when the counter reaches 7 (STARVE_MAX=8); STALL_om=1 that cycle.
- RST mid-S_WB with HRD_ACK in previous cycle -> next cycle state S_INIT, OMSRC=1, no HRD_VALID.
- With OM_COLLISION_CHK_EN: EN_wb pulse in S_NORM -> OM_WE=0, COLLISION_ERR=1 next cycle and held until RST.
